rob_interface: RTL and testbench
================================

// Module: rob_interface
// PURPOSE
// - Dispatch stage between ROB allocation and the two reservation stations (ALU, LS).
// - Resolves source operands A/B and NZCV: regfile, completed ROB entry, or same-cycle broadcast bypass.
// - Tracks pending STUR count, applies RS-full backpressure, and registers one dispatch bundle per cycle.
// PARAMETERS
// - GPR_SIZE      64  operand/value width
// - ROB_IDX_SIZE  4   ROB index width
// - STUR_CNT_W    4   pending-store counter width (saturating)
// PORTS
// - in_clk            in   1             single clock, rising edge
// - in_rst_n          in   1             synchronous, active-low reset
// - in_dispatch_valid in   1             decoded instr with allocated ROB slot
// - in_fu_id          in   fu_id_t       FU_ALU / FU_LS target
// - in_fu_op          in   fu_op_t       operation (FU_OP_LDUR, FU_OP_STUR, ...)
// - in_dst_rob_index  in   ROB_IDX_SIZE  destination ROB slot
// - in_set_nzcv       in   1             instr writes flags
// - in_uses_nzcv      in   1             instr reads flags
// - in_cond_codes     in   4             branch condition, passthrough
// - in_{a,b}_in_flight in  1             producer not yet retired to regfile
// - in_{a,b}_rob_index in  ROB_IDX_SIZE  producer ROB slot
// - in_{a,b}_reg_value in  GPR_SIZE      regfile read value
// - in_{a,b}_rob_done  in  1             producer ROB entry completed
// - in_{a,b}_rob_value in  GPR_SIZE      producer ROB entry value
// - in_nzcv_in_flight, in_nzcv_rob_index, in_nzcv_reg, in_nzcv_rob_done, in_nzcv_rob_value: same scheme, nzcv_t
// - in_bcast_done/index/value/set_nzcv/nzcv  in  1/ROB_IDX/GPR/1/nzcv_t  FU result broadcast
// - in_rs_alu_has_free, in_rs_ls_has_free    in  1  RS free-slot flags
// - in_stur_retire    in   1             one STUR committed to memory
// - in_mispred        in   1             flush in-flight dispatch
// - out_stall         out  1             comb: dispatch_valid & target RS full
// - out_sigs          out  rob_sigs_t    registered bundle: done, fu_id, fu_op, dst_rob_index,
//                                        val_{a,b}_{valid,value,rob_index}, nzcv_{valid,rob_index},
//                                        nzcv, set_nzcv, uses_nzcv, cond_codes, stur_counter
// BEHAVIOUR
// - Latency 1: bundle reflects inputs sampled at previous rising edge.
// - Accept = in_dispatch_valid & ~out_stall & ~in_mispred; out_sigs.done <= accept (1-cycle pulse).
// - Operand resolution, priority per source:
//   1 ~in_flight -> valid=1, value=reg_value
//   2 in_bcast_done & bcast_index==rob_index -> valid=1, value=bcast_value
//   3 rob_done -> valid=1, value=rob_value
//   4 else -> valid=0, value=0, rob_index kept for later RS wakeup
// - NZCV: same priority; bypass also requires in_bcast_set_nzcv; ~in_uses_nzcv -> nzcv_valid=1.
// - Non-accepted cycle: done=0; other fields may hold stale data, RS must ignore them.
// - stur_counter: +1 on accepted FU_OP_STUR, -1 on in_stur_retire; both together -> unchanged.
//   Saturates at 0 and 2^STUR_CNT_W-1; output = value after update.
// - in_mispred: drops same-cycle dispatch (no increment); counter otherwise unaffected.
// - Reset (in_rst_n=0 at edge): all out_sigs fields 0, stur_counter 0; dominates all other inputs.
// STRUCTURE
// - Shared package: fu_id_t, fu_op_t, nzcv_t, rob_sigs_t, GPR_SIZE, ROB_IDX_SIZE.
// - One sub-module operand_resolver, instantiated for A, B, NZCV (value width parameterised).
// TESTING
// - A not in flight reg=5, B rob_done value=7 -> next cycle done=1, a=(1,5), b=(1,7).
// - A in flight idx 3, not done, bcast idx 3 val -2 same cycle -> a_valid=1, a_value=-2.
// - A in flight idx 3, no bcast/done -> a_valid=0, a_rob_index=3.
// - LS op with in_rs_ls_has_free=0 -> out_stall=1, next done=0; ALU op same cycle unaffected.
// - Three STUR dispatches, then retire+STUR same cycle -> counter 1,2,3,3; retire at 0 stays 0.
// - Dispatch with in_mispred=1, or in_rst_n=0 mid-stream -> done=0; reset clears counter.

Source files
------------

// File: rtl/rob_interface_pkg.sv
// rtl/rob_interface_pkg.sv - shared types and widths for the dispatch / ROB interface
// Contents: GPR_SIZE, ROB_IDX_SIZE, STUR_CNT_W, fu_id_t, fu_op_t, nzcv_t, rob_sigs_t
package rob_interface_pkg;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 4;
  localparam int STUR_CNT_W   = 4;

  typedef enum logic {
    FU_ALU = 1'b0,
    FU_LS  = 1'b1
  } fu_id_t;

  typedef enum logic [3:0] {
    FU_OP_ADD    = 4'd0,
    FU_OP_SUB    = 4'd1,
    FU_OP_AND    = 4'd2,
    FU_OP_ORR    = 4'd3,
    FU_OP_MOV    = 4'd4,
    FU_OP_B_COND = 4'd5,
    FU_OP_LDUR   = 4'd6,
    FU_OP_STUR   = 4'd7
  } fu_op_t;

  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic                    done;
    fu_id_t                  fu_id;
    fu_op_t                  fu_op;
    logic [ROB_IDX_SIZE-1:0] dst_rob_index;
    logic                    val_a_valid;
    logic [GPR_SIZE-1:0]     val_a_value;
    logic [ROB_IDX_SIZE-1:0] val_a_rob_index;
    logic                    val_b_valid;
    logic [GPR_SIZE-1:0]     val_b_value;
    logic [ROB_IDX_SIZE-1:0] val_b_rob_index;
    logic                    nzcv_valid;
    logic [ROB_IDX_SIZE-1:0] nzcv_rob_index;
    nzcv_t                   nzcv;
    logic                    set_nzcv;
    logic                    uses_nzcv;
    logic [3:0]              cond_codes;
    logic [STUR_CNT_W-1:0]   stur_counter;
  } rob_sigs_t;

endpackage

// File: rtl/rob_interface_operand_resolver.sv
// rtl/rob_interface_operand_resolver.sv - picks one source operand from regfile, broadcast or completed ROB entry
// Ports: in_flight/rob_index/reg_value/rob_done/rob_value describe the source,
//        bcast_done/bcast_ok/bcast_index/bcast_value describe this cycle's FU broadcast,
//        valid/value are the resolved operand (value 0 when still waiting on the producer).
module operand_resolver
  import rob_interface_pkg::*;
#(
  parameter int W = GPR_SIZE
) (
  input  logic                    in_flight,
  input  logic [ROB_IDX_SIZE-1:0] rob_index,
  input  logic [W-1:0]            reg_value,
  input  logic                    rob_done,
  input  logic [W-1:0]            rob_value,
  input  logic                    bcast_done,
  input  logic                    bcast_ok,
  input  logic [ROB_IDX_SIZE-1:0] bcast_index,
  input  logic [W-1:0]            bcast_value,
  output logic                    valid,
  output logic [W-1:0]            value
);

  // bcast_ok lets the flags instance require that the broadcasting instr actually wrote NZCV.
  always_comb begin
    valid = 1'b0;
    value = '0;
    if (!in_flight) begin
      valid = 1'b1;
      value = reg_value;
    end else if (bcast_done && bcast_ok && (bcast_index == rob_index)) begin
      valid = 1'b1;
      value = bcast_value;
    end else if (rob_done) begin
      valid = 1'b1;
      value = rob_value;
    end
  end

endmodule

// File: rtl/rob_interface.sv
// rtl/rob_interface.sv - dispatch stage: operand resolution, RS backpressure, pending-STUR count, registered bundle
// Ports: in_clk/in_rst_n clock and sync active-low reset; in_dispatch_valid/in_fu_*/in_dst_rob_index/
//        in_*nzcv*/in_cond_codes describe the instr; in_{a,b,nzcv}_* source lookups; in_bcast_* FU
//        broadcast; in_rs_*_has_free RS space; in_stur_retire store commit; in_mispred flush;
//        out_stall comb backpressure; out_sigs registered dispatch bundle.
module rob_interface
  import rob_interface_pkg::*;
(
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_dispatch_valid,
  input  fu_id_t                  in_fu_id,
  input  fu_op_t                  in_fu_op,
  input  logic [ROB_IDX_SIZE-1:0] in_dst_rob_index,
  input  logic                    in_set_nzcv,
  input  logic                    in_uses_nzcv,
  input  logic [3:0]              in_cond_codes,
  input  logic                    in_a_in_flight,
  input  logic [ROB_IDX_SIZE-1:0] in_a_rob_index,
  input  logic [GPR_SIZE-1:0]     in_a_reg_value,
  input  logic                    in_a_rob_done,
  input  logic [GPR_SIZE-1:0]     in_a_rob_value,
  input  logic                    in_b_in_flight,
  input  logic [ROB_IDX_SIZE-1:0] in_b_rob_index,
  input  logic [GPR_SIZE-1:0]     in_b_reg_value,
  input  logic                    in_b_rob_done,
  input  logic [GPR_SIZE-1:0]     in_b_rob_value,
  input  logic                    in_nzcv_in_flight,
  input  logic [ROB_IDX_SIZE-1:0] in_nzcv_rob_index,
  input  nzcv_t                   in_nzcv_reg,
  input  logic                    in_nzcv_rob_done,
  input  nzcv_t                   in_nzcv_rob_value,
  input  logic                    in_bcast_done,
  input  logic [ROB_IDX_SIZE-1:0] in_bcast_index,
  input  logic [GPR_SIZE-1:0]     in_bcast_value,
  input  logic                    in_bcast_set_nzcv,
  input  nzcv_t                   in_bcast_nzcv,
  input  logic                    in_rs_alu_has_free,
  input  logic                    in_rs_ls_has_free,
  input  logic                    in_stur_retire,
  input  logic                    in_mispred,
  output logic                    out_stall,
  output rob_sigs_t               out_sigs
);

  localparam logic [STUR_CNT_W-1:0] STUR_MAX = '1;
  localparam logic [STUR_CNT_W-1:0] STUR_ONE = STUR_CNT_W'(1);

  logic                  a_valid, b_valid, nzcv_res_valid;
  logic [GPR_SIZE-1:0]   a_value, b_value;
  nzcv_t                 nzcv_value;
  logic                  accept;
  logic                  stur_inc;
  logic [STUR_CNT_W-1:0] stur_next;
  rob_sigs_t             next_sigs;

  operand_resolver #(.W(GPR_SIZE)) u_res_a (
    .in_flight   (in_a_in_flight),
    .rob_index   (in_a_rob_index),
    .reg_value   (in_a_reg_value),
    .rob_done    (in_a_rob_done),
    .rob_value   (in_a_rob_value),
    .bcast_done  (in_bcast_done),
    .bcast_ok    (1'b1),
    .bcast_index (in_bcast_index),
    .bcast_value (in_bcast_value),
    .valid       (a_valid),
    .value       (a_value)
  );

  operand_resolver #(.W(GPR_SIZE)) u_res_b (
    .in_flight   (in_b_in_flight),
    .rob_index   (in_b_rob_index),
    .reg_value   (in_b_reg_value),
    .rob_done    (in_b_rob_done),
    .rob_value   (in_b_rob_value),
    .bcast_done  (in_bcast_done),
    .bcast_ok    (1'b1),
    .bcast_index (in_bcast_index),
    .bcast_value (in_bcast_value),
    .valid       (b_valid),
    .value       (b_value)
  );

  operand_resolver #(.W(4)) u_res_nzcv (
    .in_flight   (in_nzcv_in_flight),
    .rob_index   (in_nzcv_rob_index),
    .reg_value   (in_nzcv_reg),
    .rob_done    (in_nzcv_rob_done),
    .rob_value   (in_nzcv_rob_value),
    .bcast_done  (in_bcast_done),
    .bcast_ok    (in_bcast_set_nzcv),
    .bcast_index (in_bcast_index),
    .bcast_value (in_bcast_nzcv),
    .valid       (nzcv_res_valid),
    .value       (nzcv_value)
  );

  always_comb begin
    out_stall = 1'b0;
    if (in_dispatch_valid) begin
      out_stall = (in_fu_id == FU_ALU) ? !in_rs_alu_has_free : !in_rs_ls_has_free;
    end
  end

  assign accept   = in_dispatch_valid && !out_stall && !in_mispred;
  assign stur_inc = accept && (in_fu_op == FU_OP_STUR);

  // Simultaneous increment and retire cancel; otherwise step and clamp at both ends.
  always_comb begin
    stur_next = out_sigs.stur_counter;
    if (stur_inc && !in_stur_retire && (out_sigs.stur_counter != STUR_MAX)) begin
      stur_next = out_sigs.stur_counter + STUR_ONE;
    end else if (in_stur_retire && !stur_inc && (out_sigs.stur_counter != '0)) begin
      stur_next = out_sigs.stur_counter - STUR_ONE;
    end
  end

  // Payload is loaded every cycle; the RS only looks at it when done is set.
  always_comb begin
    next_sigs                 = '0;
    next_sigs.done            = accept;
    next_sigs.fu_id           = in_fu_id;
    next_sigs.fu_op           = in_fu_op;
    next_sigs.dst_rob_index   = in_dst_rob_index;
    next_sigs.val_a_valid     = a_valid;
    next_sigs.val_a_value     = a_value;
    next_sigs.val_a_rob_index = in_a_rob_index;
    next_sigs.val_b_valid     = b_valid;
    next_sigs.val_b_value     = b_value;
    next_sigs.val_b_rob_index = in_b_rob_index;
    next_sigs.nzcv_valid      = nzcv_res_valid || !in_uses_nzcv;
    next_sigs.nzcv_rob_index  = in_nzcv_rob_index;
    next_sigs.nzcv            = nzcv_value;
    next_sigs.set_nzcv        = in_set_nzcv;
    next_sigs.uses_nzcv       = in_uses_nzcv;
    next_sigs.cond_codes      = in_cond_codes;
    next_sigs.stur_counter    = stur_next;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      out_sigs <= '0;
    end else begin
      out_sigs <= next_sigs;
    end
  end

endmodule

// File: tb/tb_rob_interface.sv
// tb/tb_rob_interface.sv - directed scoreboard bench for rob_interface
module tb_rob_interface;
  import rob_interface_pkg::*;

  logic                    in_clk = 1'b0;
  logic                    in_rst_n;
  logic                    in_dispatch_valid;
  fu_id_t                  in_fu_id;
  fu_op_t                  in_fu_op;
  logic [ROB_IDX_SIZE-1:0] in_dst_rob_index;
  logic                    in_set_nzcv, in_uses_nzcv;
  logic [3:0]              in_cond_codes;
  logic                    in_a_in_flight, in_a_rob_done;
  logic [ROB_IDX_SIZE-1:0] in_a_rob_index;
  logic [GPR_SIZE-1:0]     in_a_reg_value, in_a_rob_value;
  logic                    in_b_in_flight, in_b_rob_done;
  logic [ROB_IDX_SIZE-1:0] in_b_rob_index;
  logic [GPR_SIZE-1:0]     in_b_reg_value, in_b_rob_value;
  logic                    in_nzcv_in_flight, in_nzcv_rob_done;
  logic [ROB_IDX_SIZE-1:0] in_nzcv_rob_index;
  nzcv_t                   in_nzcv_reg, in_nzcv_rob_value;
  logic                    in_bcast_done, in_bcast_set_nzcv;
  logic [ROB_IDX_SIZE-1:0] in_bcast_index;
  logic [GPR_SIZE-1:0]     in_bcast_value;
  nzcv_t                   in_bcast_nzcv;
  logic                    in_rs_alu_has_free, in_rs_ls_has_free;
  logic                    in_stur_retire, in_mispred;
  logic                    out_stall;
  rob_sigs_t               out_sigs;

  typedef struct {
    rob_sigs_t s;
    bit        full;
    bit        ops;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 in_clk = ~in_clk;

  rob_interface dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_dispatch_valid(in_dispatch_valid),
    .in_fu_id(in_fu_id), .in_fu_op(in_fu_op), .in_dst_rob_index(in_dst_rob_index),
    .in_set_nzcv(in_set_nzcv), .in_uses_nzcv(in_uses_nzcv), .in_cond_codes(in_cond_codes),
    .in_a_in_flight(in_a_in_flight), .in_a_rob_index(in_a_rob_index),
    .in_a_reg_value(in_a_reg_value), .in_a_rob_done(in_a_rob_done), .in_a_rob_value(in_a_rob_value),
    .in_b_in_flight(in_b_in_flight), .in_b_rob_index(in_b_rob_index),
    .in_b_reg_value(in_b_reg_value), .in_b_rob_done(in_b_rob_done), .in_b_rob_value(in_b_rob_value),
    .in_nzcv_in_flight(in_nzcv_in_flight), .in_nzcv_rob_index(in_nzcv_rob_index),
    .in_nzcv_reg(in_nzcv_reg), .in_nzcv_rob_done(in_nzcv_rob_done), .in_nzcv_rob_value(in_nzcv_rob_value),
    .in_bcast_done(in_bcast_done), .in_bcast_index(in_bcast_index), .in_bcast_value(in_bcast_value),
    .in_bcast_set_nzcv(in_bcast_set_nzcv), .in_bcast_nzcv(in_bcast_nzcv),
    .in_rs_alu_has_free(in_rs_alu_has_free), .in_rs_ls_has_free(in_rs_ls_has_free),
    .in_stur_retire(in_stur_retire), .in_mispred(in_mispred),
    .out_stall(out_stall), .out_sigs(out_sigs)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sigs(input string tag, input rob_sigs_t exp);
    checks++;
    assert (out_sigs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, out_sigs, exp);
    end
  endtask

  function automatic exp_t mk(input bit done, input int stur);
    exp_t e;
    e.s              = '0;
    e.s.done         = done;
    e.s.stur_counter = STUR_CNT_W'(stur);
    e.full           = 1'b0;
    e.ops            = 1'b0;
    return e;
  endfunction

  task automatic clr();
    in_rst_n = 1'b1; in_dispatch_valid = 1'b0; in_fu_id = FU_ALU; in_fu_op = FU_OP_ADD;
    in_dst_rob_index = '0; in_set_nzcv = 1'b0; in_uses_nzcv = 1'b0; in_cond_codes = '0;
    in_a_in_flight = 1'b0; in_a_rob_index = '0; in_a_reg_value = '0; in_a_rob_done = 1'b0; in_a_rob_value = '0;
    in_b_in_flight = 1'b0; in_b_rob_index = '0; in_b_reg_value = '0; in_b_rob_done = 1'b0; in_b_rob_value = '0;
    in_nzcv_in_flight = 1'b0; in_nzcv_rob_index = '0; in_nzcv_reg = '0; in_nzcv_rob_done = 1'b0;
    in_nzcv_rob_value = '0; in_bcast_done = 1'b0; in_bcast_index = '0; in_bcast_value = '0;
    in_bcast_set_nzcv = 1'b0; in_bcast_nzcv = '0; in_rs_alu_has_free = 1'b1; in_rs_ls_has_free = 1'b1;
    in_stur_retire = 1'b0; in_mispred = 1'b0;
  endtask

  // One clock: the bundle registered at this edge is compared against the oldest expectation.
  task automatic step(input string tag);
    exp_t e;
    @(posedge in_clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_done"}, 64'(out_sigs.done), 64'(e.s.done));
      chk({tag, "_stur"}, 64'(out_sigs.stur_counter), 64'(e.s.stur_counter));
      if (e.full) chk_sigs({tag, "_all"}, e.s);
      if (e.ops) begin
        chk({tag, "_fu_id"}, 64'(out_sigs.fu_id), 64'(e.s.fu_id));
        chk({tag, "_fu_op"}, 64'(out_sigs.fu_op), 64'(e.s.fu_op));
        chk({tag, "_dst"}, 64'(out_sigs.dst_rob_index), 64'(e.s.dst_rob_index));
        chk({tag, "_a_valid"}, 64'(out_sigs.val_a_valid), 64'(e.s.val_a_valid));
        chk({tag, "_a_value"}, out_sigs.val_a_value, e.s.val_a_value);
        chk({tag, "_a_idx"}, 64'(out_sigs.val_a_rob_index), 64'(e.s.val_a_rob_index));
        chk({tag, "_b_valid"}, 64'(out_sigs.val_b_valid), 64'(e.s.val_b_valid));
        chk({tag, "_b_value"}, out_sigs.val_b_value, e.s.val_b_value);
        chk({tag, "_nzcv_valid"}, 64'(out_sigs.nzcv_valid), 64'(e.s.nzcv_valid));
        chk({tag, "_nzcv_idx"}, 64'(out_sigs.nzcv_rob_index), 64'(e.s.nzcv_rob_index));
        chk({tag, "_nzcv"}, 64'(out_sigs.nzcv), 64'(e.s.nzcv));
      end
    end
  endtask

  initial begin
    exp_t e;
    clr();

    // Reset with a STUR dispatch pending: reset must win.
    in_rst_n = 1'b0; in_dispatch_valid = 1'b1; in_fu_id = FU_LS; in_fu_op = FU_OP_STUR;
    e = mk(0, 0); e.full = 1'b1; sb.push_back(e); step("rst0");
    e = mk(0, 0); e.full = 1'b1; sb.push_back(e); step("rst1");

    // A from regfile, B from completed ROB entry.
    clr(); in_dispatch_valid = 1'b1; in_dst_rob_index = 4'd1;
    in_a_reg_value = 64'd5; in_b_in_flight = 1'b1; in_b_rob_index = 4'd2;
    in_b_rob_done = 1'b1; in_b_rob_value = 64'd7;
    #1 chk("t1_stall", 64'(out_stall), 64'd0);
    e = mk(1, 0); e.ops = 1'b1; e.s.dst_rob_index = 4'd1;
    e.s.val_a_valid = 1'b1; e.s.val_a_value = 64'd5; e.s.val_b_valid = 1'b1; e.s.val_b_value = 64'd7;
    e.s.nzcv_valid = 1'b1; sb.push_back(e); step("t1");

    // Broadcast bypass beats a completed ROB entry; flags stay pending without set_nzcv.
    clr(); in_dispatch_valid = 1'b1; in_fu_op = FU_OP_SUB; in_dst_rob_index = 4'd2;
    in_a_in_flight = 1'b1; in_a_rob_index = 4'd3; in_a_rob_done = 1'b1; in_a_rob_value = 64'd99;
    in_bcast_done = 1'b1; in_bcast_index = 4'd3; in_bcast_value = 64'hFFFF_FFFF_FFFF_FFFE;
    in_b_reg_value = 64'd11; in_uses_nzcv = 1'b1; in_nzcv_in_flight = 1'b1; in_nzcv_rob_index = 4'd5;
    e = mk(1, 0); e.ops = 1'b1; e.s.fu_op = FU_OP_SUB; e.s.dst_rob_index = 4'd2;
    e.s.val_a_valid = 1'b1; e.s.val_a_value = 64'hFFFF_FFFF_FFFF_FFFE; e.s.val_a_rob_index = 4'd3;
    e.s.val_b_valid = 1'b1; e.s.val_b_value = 64'd11;
    e.s.nzcv_valid = 1'b0; e.s.nzcv_rob_index = 4'd5; sb.push_back(e); step("t2");

    // A waits on slot 3; flags bypassed from a flag-setting broadcast on slot 4.
    clr(); in_dispatch_valid = 1'b1; in_dst_rob_index = 4'd6;
    in_a_in_flight = 1'b1; in_a_rob_index = 4'd3; in_uses_nzcv = 1'b1;
    in_nzcv_in_flight = 1'b1; in_nzcv_rob_index = 4'd4;
    in_bcast_done = 1'b1; in_bcast_index = 4'd4; in_bcast_set_nzcv = 1'b1; in_bcast_nzcv = 4'b1010;
    in_bcast_value = 64'd123;
    e = mk(1, 0); e.ops = 1'b1; e.s.dst_rob_index = 4'd6;
    e.s.val_a_valid = 1'b0; e.s.val_a_value = 64'd0; e.s.val_a_rob_index = 4'd3;
    e.s.val_b_valid = 1'b1; e.s.val_b_value = 64'd0;
    e.s.nzcv_valid = 1'b1; e.s.nzcv_rob_index = 4'd4; e.s.nzcv = 4'b1010; sb.push_back(e); step("t3");

    // LS full stalls an LDUR, but an ALU op is unaffected.
    clr(); in_dispatch_valid = 1'b1; in_fu_id = FU_LS; in_fu_op = FU_OP_LDUR; in_rs_ls_has_free = 1'b0;
    #1 chk("ls_full_stall", 64'(out_stall), 64'd1);
    sb.push_back(mk(0, 0)); step("ls_full");
    in_fu_id = FU_ALU; in_fu_op = FU_OP_ADD; in_dst_rob_index = 4'd7;
    #1 chk("alu_ok_stall", 64'(out_stall), 64'd0);
    e = mk(1, 0); e.ops = 1'b1; e.s.dst_rob_index = 4'd7; e.s.val_a_valid = 1'b1; e.s.val_b_valid = 1'b1;
    e.s.nzcv_valid = 1'b1; sb.push_back(e); step("alu_ok");

    // STUR counting: 1,2,3, then STUR+retire holds 3, then drain past zero.
    clr(); in_dispatch_valid = 1'b1; in_fu_id = FU_LS; in_fu_op = FU_OP_STUR;
    sb.push_back(mk(1, 1)); step("stur1");
    sb.push_back(mk(1, 2)); step("stur2");
    sb.push_back(mk(1, 3)); step("stur3");
    in_stur_retire = 1'b1;
    sb.push_back(mk(1, 3)); step("stur_ret");
    in_dispatch_valid = 1'b0;
    sb.push_back(mk(0, 2)); step("ret2");
    sb.push_back(mk(0, 1)); step("ret1");
    sb.push_back(mk(0, 0)); step("ret0");
    sb.push_back(mk(0, 0)); step("ret_floor");

    // Mispredict drops the STUR.
    clr(); in_dispatch_valid = 1'b1; in_fu_id = FU_LS; in_fu_op = FU_OP_STUR; in_mispred = 1'b1;
    sb.push_back(mk(0, 0)); step("mispred");
    in_mispred = 1'b0;
    sb.push_back(mk(1, 1)); step("stur_after");

    // Saturation at the top of the counter.
    for (int i = 2; i <= 17; i++) begin
      sb.push_back(mk(1, (i > 15) ? 15 : i));
      step($sformatf("sat%0d", i));
    end

    // Reset mid-stream clears everything including the counter.
    in_rst_n = 1'b0;
    e = mk(0, 0); e.full = 1'b1; sb.push_back(e); step("rst_mid");
    in_rst_n = 1'b1; in_dispatch_valid = 1'b0;
    sb.push_back(mk(0, 0)); step("post_rst");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
